// File: rtl/tetris_key_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tetris_key_cmd
// Brief    : Serialises debounced key presses into a prioritised command FIFO.
//            Optional auto-repeat for LEFT/RIGHT/DOWN: TETRIS_AUTOREPEAT_EN.
// Revision : 1.0
// ============================================================================
module tetris_key_cmd #(
    parameter int DEPTH         = 4,
    parameter int DAS_DELAY     = 5000000,
    parameter int REPEAT_PERIOD = 1250000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             key_pulse,
    input  logic [4:0]             key_held,
    output logic [2:0]             cmd,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   dropped,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam int K_LEFT   = 0;
    localparam int K_RIGHT  = 1;
    localparam int K_ROTATE = 2;
    localparam int K_DOWN   = 3;
    localparam int K_DROP   = 4;

    logic [4:0]    pending_q, pending_d;
    logic [4:0]    sel_hot;
    logic [4:0]    clr;
    logic [4:0]    tick;
    logic [2:0]    sel_cmd;
    logic          push;
    logic          pop;
    logic          dropped_q, dropped_d;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    assign cmd_valid  = (count_q != '0);
    assign cmd        = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign fifo_count = count_q;
    assign dropped    = dropped_q;
    assign pop        = cmd_valid && cmd_ready;

    // Fixed priority DROP > ROTATE > LEFT > RIGHT > DOWN; command code equals key index.
    always_comb begin
        sel_hot = '0;
        sel_cmd = 3'd0;
        if (pending_q[K_DROP]) begin
            sel_hot[K_DROP] = 1'b1;
            sel_cmd         = 3'(K_DROP);
        end else if (pending_q[K_ROTATE]) begin
            sel_hot[K_ROTATE] = 1'b1;
            sel_cmd           = 3'(K_ROTATE);
        end else if (pending_q[K_LEFT]) begin
            sel_hot[K_LEFT] = 1'b1;
            sel_cmd         = 3'(K_LEFT);
        end else if (pending_q[K_RIGHT]) begin
            sel_hot[K_RIGHT] = 1'b1;
            sel_cmd          = 3'(K_RIGHT);
        end else if (pending_q[K_DOWN]) begin
            sel_hot[K_DOWN] = 1'b1;
            sel_cmd         = 3'(K_DOWN);
        end
    end

    assign push = (|pending_q) && ((count_q < CW'(DEPTH)) || pop);
    assign clr  = push ? sel_hot : 5'd0;

    // Set wins over clear so an event arriving on the selection edge is kept.
    assign pending_d = (pending_q & ~clr) | key_pulse | tick;
    assign dropped_d = |(key_pulse & pending_q & ~clr);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            dropped_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sel_cmd;
    end

`ifdef TETRIS_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_e;

    localparam logic [23:0] C_DAS_LAST = 24'(DAS_DELAY - 1);
    localparam logic [23:0] C_REP_LAST = 24'(REPEAT_PERIOD - 1);

    logic unused_held;
    assign unused_held  = ^{key_held[K_ROTATE], key_held[K_DROP]};
    assign tick[K_ROTATE] = 1'b0;
    assign tick[K_DROP]   = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_rep
        localparam int KEY = (g == 0) ? K_LEFT : (g == 1) ? K_RIGHT : K_DOWN;

        rep_state_e  state_q, state_d;
        logic [23:0] cnt_q, cnt_d;
        logic        rep_tick;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            rep_tick = 1'b0;
            if (key_pulse[KEY]) begin
                state_d = S_DELAY;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    S_DELAY: begin
                        if (!key_held[KEY]) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == C_DAS_LAST) begin
                            rep_tick = 1'b1;
                            cnt_d    = '0;
                            state_d  = S_REPEAT;
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end
                    S_REPEAT: begin
                        if (!key_held[KEY]) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == C_REP_LAST) begin
                            rep_tick = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign tick[KEY] = rep_tick;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{key_held, 24'(DAS_DELAY), 24'(REPEAT_PERIOD)};
    assign tick       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tetris_key_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_key_cmd
// Brief    : Directed self-checking bench for tetris_key_cmd (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_tetris_key_cmd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_pulse;
    logic [4:0] key_held;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       dropped;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

`ifdef TETRIS_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    always #5 clk = ~clk;

    tetris_key_cmd #(
        .DEPTH         (4),
        .DAS_DELAY     (8),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_pulse  (key_pulse),
        .key_held   (key_held),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .dropped    (dropped),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c, input logic [2:0] n);
        chk({tag, "_valid"}, cmd_valid, v);
        chk({tag, "_cmd"}, cmd, c);
        chk({tag, "_count"}, fifo_count, n);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_pulse = '0;
        key_held  = '0;
        cmd_ready = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 3'd0, 3'd0);
        chk("reset_dropped", dropped, 1'b0);
        rst_n = 1'b1;
        step();

        // Single LEFT press, 2-cycle latency, one-cycle visibility.
        cmd_ready = 1'b1;
        key_pulse = 5'b00001;
        step();
        key_pulse = '0;
        chk_out("single_e0", 1'b0, 3'd0, 3'd0);
        step();
        chk_out("single_e1", 1'b1, 3'd0, 3'd1);
        step();
        chk_out("single_e2", 1'b0, 3'd0, 3'd0);

        // DROP|LEFT|DOWN together -> 4, 0, 3.
        key_pulse = 5'b11001;
        step();
        key_pulse = '0;
        step();
        chk_out("simul_1", 1'b1, 3'd4, 3'd1);
        step();
        chk_out("simul_2", 1'b1, 3'd0, 3'd1);
        step();
        chk_out("simul_3", 1'b1, 3'd3, 3'd1);
        step();
        chk_out("simul_end", 1'b0, 3'd0, 3'd0);

        // Backpressure: ROTATE, RIGHT, LEFT, DOWN, DROP; DROP stays pending.
        cmd_ready = 1'b0;
        key_pulse = 5'b00100; step();
        key_pulse = 5'b00010; step();
        key_pulse = 5'b00001; step();
        key_pulse = 5'b01000; step();
        key_pulse = 5'b10000; step();
        key_pulse = '0;
        chk_out("full_a", 1'b1, 3'd2, 3'd4);
        step();
        chk_out("full_b", 1'b1, 3'd2, 3'd4);
        chk("full_nodrop", dropped, 1'b0);
        key_pulse = 5'b10000;
        step();
        key_pulse = '0;
        chk("drop_pulse", dropped, 1'b1);
        step();
        chk("drop_clear", dropped, 1'b0);
        cmd_ready = 1'b1;
        step();
        chk_out("drain_0", 1'b1, 3'd1, 3'd4);
        step();
        chk_out("drain_1", 1'b1, 3'd0, 3'd3);
        step();
        chk_out("drain_2", 1'b1, 3'd3, 3'd2);
        step();
        chk_out("drain_3", 1'b1, 3'd4, 3'd1);
        step();
        chk_out("drain_end", 1'b0, 3'd0, 3'd0);

        // Full FIFO with RIGHT pending: one pop lets RIGHT in, count stays 4.
        cmd_ready = 1'b0;
        key_pulse = 5'b11101;
        step();
        key_pulse = '0;
        step(); step(); step(); step();
        chk_out("pp_full", 1'b1, 3'd4, 3'd4);
        key_pulse = 5'b00010;
        step();
        key_pulse = '0;
        step();
        chk_out("pp_hold", 1'b1, 3'd4, 3'd4);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk_out("pp_swap", 1'b1, 3'd2, 3'd4);
        step();
        chk_out("pp_stay", 1'b1, 3'd2, 3'd4);
        cmd_ready = 1'b1;
        step();
        chk_out("pp_d1", 1'b1, 3'd0, 3'd3);
        step();
        chk_out("pp_d2", 1'b1, 3'd3, 3'd2);
        step();
        chk_out("pp_d3", 1'b1, 3'd1, 3'd1);
        step();
        chk_out("pp_end", 1'b0, 3'd0, 3'd0);

        // Held LEFT: initial command, then repeats at +8,+11,+14,+17 when enabled.
        key_pulse = 5'b00001;
        key_held  = 5'b00001;
        step();
        key_pulse = '0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 19) key_held = '0;
            chk("rep_valid", cmd_valid,
                (n == 1) || (AR && (n == 9 || n == 12 || n == 15 || n == 18)));
        end
        chk_out("rep_end", 1'b0, 3'd0, 3'd0);

        // Asynchronous reset with 3 queued and 2 pending.
        cmd_ready = 1'b0;
        key_pulse = 5'b11111;
        step();
        key_pulse = '0;
        step(); step(); step();
        chk_out("prerst", 1'b1, 3'd4, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 3'd0, 3'd0);
        chk("async_rst_dropped", dropped, 1'b0);
        step();
        rst_n     = 1'b1;
        cmd_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("post_rst_idle", cmd_valid, 1'b0);
        end
        key_pulse = 5'b00100;
        step();
        key_pulse = '0;
        step();
        chk_out("post_rst_new", 1'b1, 3'd2, 3'd1);
        step();
        chk_out("post_rst_end", 1'b0, 3'd0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tetris_key_cmd.md
# tetris_key_cmd

Converts the one-cycle press pulses from the five per-button debouncers into an ordered stream of game commands for the Tetris game-logic FSM. It sits directly downstream of the debouncers. Simultaneous presses are serialised by fixed priority through a pending-bit register. Commands are buffered in a small FIFO with a valid/ready handshake, and held LEFT/RIGHT/DOWN keys can optionally auto-repeat.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- DAS_DELAY, 5000000: cycles from press to first auto-repeat; must be ≥ 1.
- REPEAT_PERIOD, 1250000: cycles between subsequent auto-repeats; must be ≥ 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- key_pulse  in  5  one-cycle press pulses from the debouncers: [0] LEFT, [1] RIGHT, [2] ROTATE, [3] DOWN, [4] DROP.
- key_held  in  5  debounced key levels, same bit order; used only for auto-repeat.
- cmd  out  3  head-of-FIFO command: 0 LEFT, 1 RIGHT, 2 ROTATE, 3 DOWN, 4 DROP.
- cmd_valid  out  1  FIFO not empty.
- cmd_ready  in  1  consumer accepts `cmd` this cycle.
- dropped  out  1  one-cycle pulse: a key_pulse hit a bit that was already pending.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- pending[4:0] register, with set-priority per bit:
  - A bit is set by a key_pulse, or by an auto-repeat tick.
  - A bit is cleared when it is selected for push.
  - Clear and set on the same edge: the bit stays set; the new event is kept.
- Selector: highest-priority pending bit, order DROP > ROTATE > LEFT > RIGHT > DOWN. It is encoded to a 3-bit command.
- Push condition: any pending bit set AND (fifo_count < DEPTH OR pop this cycle). At most one push per cycle.
- Pop condition: cmd_valid && cmd_ready.
- FIFO is first-word-fall-through. `cmd` is 0 when empty.
- Simultaneous push and pop: legal at any occupancy, including full. Occupancy is unchanged.
- FIFO full and no pop: pending bits hold. No command is lost; newer presses of the same key coalesce.
- dropped: asserted the cycle after a key_pulse bit arrives while that bit is already set and not being cleared that cycle. Auto-repeat coalescing never asserts dropped.
- Read and write pointers wrap modulo DEPTH.
- All outputs reset to 0: cmd, cmd_valid, dropped, fifo_count. Reset also clears pending, the FIFO pointers and all repeat FSMs. Reset is asynchronous mid-operation, and all in-flight commands are discarded.

## Timing
- key_pulse sampled at edge E sets pending at E. The push occurs at edge E+1, and cmd_valid is high after E+1, i.e. 2-cycle latency when the FIFO is not full.
- Pop at edge P: the next entry, or cmd_valid=0, is visible after P.
- Same-cycle pulses on k keys: commands appear on k consecutive cycles in priority order, provided the consumer holds cmd_ready=1.
- Auto-repeat FSM, one per key for LEFT, RIGHT and DOWN, with states IDLE, DELAY, REPEAT and a 24-bit counter:
  - IDLE → DELAY on key_pulse; counter cleared.
  - DELAY: increments each cycle while key_held. At count DAS_DELAY−1 it raises a tick (sets pending), clears the counter and enters REPEAT.
  - REPEAT: ticks every REPEAT_PERIOD cycles while key_held.
  - key_held=0 in DELAY or REPEAT → IDLE the next edge, with no tick.
  - key_pulse in DELAY or REPEAT restarts DELAY.

## Configuration
- TETRIS_AUTOREPEAT_EN defined: the three repeat FSMs and counters are built; key_held is used.
- TETRIS_AUTOREPEAT_EN undefined: there is no repeat logic and key_held is ignored. Commands come only from key_pulse; DAS_DELAY and REPEAT_PERIOD are unused.

## Test plan
- Single press: LEFT pulse at cycle 10, cmd_ready=1 → cmd_valid=1, cmd=0 at cycle 12 for exactly one cycle; fifo_count returns to 0.
- Simultaneous keys: pulses DROP|LEFT|DOWN in one cycle, cmd_ready=1 → cmds 4, 0, 3 on three consecutive cycles.
- Backpressure and full: cmd_ready=0 with DEPTH=4; pulse ROTATE, RIGHT, LEFT, DOWN, DROP in separate cycles.
  - fifo_count saturates at 4 and DROP stays pending.
  - A second DROP pulse → dropped=1 for one cycle.
  - Raising cmd_ready drains 2, 1, 0, 3, 4.
- Push and pop when full: FIFO full, pending RIGHT, cmd_ready=1 for one cycle → head popped, RIGHT pushed, fifo_count stays 4.
- Auto-repeat (TETRIS_AUTOREPEAT_EN, DAS_DELAY=8, REPEAT_PERIOD=3): LEFT pulse, key_held[0]=1 for 20 cycles.
  - Expect the initial LEFT, then repeats at +8, +11, +14, +17 cycles.
  - Release → no further commands.
  - With the macro undefined: only the initial LEFT.
- Reset mid-stream: rst_n=0 with 3 queued and 2 pending → all outputs 0 immediately; after release there are no commands until a new pulse.
